// File: rtl/toggle_sequencer.sv
// toggle_sequencer: debounces a push-button, optionally raises periodic
// requests, and issues one-clk toggle pulses to a downstream red/green light
// controller. The controller is never toggled faster than its amber interval
// plus a minimum settled dwell.
//
// Handshake: there is no valid/ready pair here. A request (debounced rising
// edge or auto timer) is latched into a one-deep pending flag and served by
// exactly one toggle pulse once the FSM is READY; further requests while
// one is latched are absorbed.
module toggle_sequencer #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd16,
    parameter logic [31:0] MIN_DWELL       = 32'd100,
    parameter logic [31:0] AMBER_TIME      = 32'd10,
    parameter logic [31:0] AUTO_PERIOD     = 32'd200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       button,
    input  logic       auto_en,
    output logic       toggle,
    output logic       phase,
    output logic       pending,
    output logic       busy,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_READY = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Terminal values; every counter clears at its terminal value.
    localparam logic [31:0] DB_LAST    = DEBOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] DWELL_LAST = MIN_DWELL - 32'd1;
    localparam logic [31:0] WAIT_LAST  = AMBER_TIME + 32'd1;
    localparam logic [31:0] AUTO_LAST  = AUTO_PERIOD - 32'd1;

    state_t      state, state_nx;
    logic        sync_q1, sync_q2;
    logic        stable;
    logic [31:0] db_cnt;
    logic [31:0] auto_cnt;
    logic [31:0] dwell_cnt, dwell_nx;
    logic [31:0] wait_cnt, wait_nx;
    logic        pending_nx, phase_nx;
    logic        fire;
    logic        auto_run;
    logic        btn_req, auto_req, req;

    // Request sources: the debounced rising edge coincides with the stable
    // level update; the auto request fires on the timer's terminal count.
    assign btn_req  = ce && sync_q2 && !stable && (db_cnt == DB_LAST);
    assign auto_run = auto_en && (state == S_READY);
    assign auto_req = ce && auto_run && (auto_cnt == AUTO_LAST);
    assign req      = btn_req || auto_req;

    assign busy      = (state == S_HOLD) || (state == S_WAIT);
    assign fsm_state = state;

    // Two-flop synchroniser for the raw button, free-running on every clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: a new level must differ for DEBOUNCE_CYCLES ce-cycles in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= 32'd0;
            stable <= 1'b0;
        end else if (ce) begin
            if (sync_q2 == stable) begin
                db_cnt <= 32'd0;
            end else if (db_cnt == DB_LAST) begin
                stable <= sync_q2;
                db_cnt <= 32'd0;
            end else begin
                db_cnt <= db_cnt + 32'd1;
            end
        end
    end

    // Auto timer: runs only while READY with auto enabled, else sits at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt <= 32'd0;
        end else if (ce) begin
            if (!auto_run || (auto_cnt == AUTO_LAST)) begin
                auto_cnt <= 32'd0;
            end else begin
                auto_cnt <= auto_cnt + 32'd1;
            end
        end
    end

    // Next-state logic: dwell in HOLD, serve one request in READY, wait out amber.
    always_comb begin
        state_nx   = state;
        dwell_nx   = dwell_cnt;
        wait_nx    = wait_cnt;
        pending_nx = pending;
        phase_nx   = phase;
        fire       = 1'b0;
        case (state)
            S_HOLD: begin
                if (req) begin
                    pending_nx = 1'b1;
                end
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_nx = 32'd0;
                    state_nx = S_READY;
                end else begin
                    dwell_nx = dwell_cnt + 32'd1;
                end
            end
            S_READY: begin
                if (ce && (pending || req)) begin
                    fire       = 1'b1;
                    phase_nx   = ~phase;
                    // A fresh request arriving alongside a latched one survives.
                    pending_nx = pending && req;
                    wait_nx    = 32'd0;
                    state_nx   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (req) begin
                    pending_nx = 1'b1;
                end
                if (wait_cnt == WAIT_LAST) begin
                    wait_nx  = 32'd0;
                    state_nx = S_HOLD;
                end else begin
                    wait_nx = wait_cnt + 32'd1;
                end
            end
            default: begin
                state_nx = S_HOLD;
                dwell_nx = 32'd0;
                wait_nx  = 32'd0;
            end
        endcase
    end

    // FSM, counters, pending and mirrored phase advance only on ce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_HOLD;
            dwell_cnt <= 32'd0;
            wait_cnt  <= 32'd0;
            pending   <= 1'b0;
            phase     <= 1'b0;
        end else if (ce) begin
            state     <= state_nx;
            dwell_cnt <= dwell_nx;
            wait_cnt  <= wait_nx;
            pending   <= pending_nx;
            phase     <= phase_nx;
        end
    end

    // Toggle pulse: set on a fire, cleared on the very next clk whatever ce is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle <= 1'b0;
        end else begin
            toggle <= fire;
        end
    end

endmodule

// File: tb/tb_toggle_sequencer.sv
// Bench for toggle_sequencer with small parameters. A timing-level model
// (remaining busy time, run lengths, ages) predicts the outputs every clk;
// directed scenarios add literal expectations on pulse timing and counts.
module tb_toggle_sequencer;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int MIN_DWELL       = 8;
    localparam int AMBER_TIME      = 3;
    localparam int AUTO_PERIOD     = 20;

    // ---------------- clock / reset / inputs ----------------
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b1;
    logic       button = 1'b0;
    logic       auto_en = 1'b0;
    logic       ce_half = 1'b0;
    logic       toggle, phase, pending, busy;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    // ce is either held high or alternates every clk.
    always @(negedge clk) ce = ce_half ? ~ce : 1'b1;

    toggle_sequencer #(
        .DEBOUNCE_CYCLES(32'd4),
        .MIN_DWELL      (32'd8),
        .AMBER_TIME     (32'd3),
        .AUTO_PERIOD    (32'd20)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .button   (button),
        .auto_en  (auto_en),
        .toggle   (toggle),
        .phase    (phase),
        .pending  (pending),
        .busy     (busy),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tog_count = 0;
    int last_tog = 0;
    int prev_tog = 0;
    int busy_run = 0;
    int last_busy_run = 0;
    bit busy_track = 0;
    logic tog_prev = 1'b0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic m_s1 = 0, m_s2 = 0, m_level = 0;
    logic m_phase = 0, m_pending = 0, m_toggle = 0;
    int   m_run = 0;
    int   m_busy_left = MIN_DWELL;
    int   m_ready_age = 0;

    task automatic model_step();
        bit req;
        bit ready;
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0;
            m_phase = 0; m_pending = 0; m_toggle = 0;
            m_run = 0; m_ready_age = 0;
            m_busy_left = MIN_DWELL;
        end else begin
            m_toggle = 0;
            if (ce) begin
                req = 0;
                if (m_s2 != m_level) begin
                    m_run++;
                    if (m_run == DEBOUNCE_CYCLES) begin
                        m_level = m_s2;
                        m_run = 0;
                        req = m_level;
                    end
                end else begin
                    m_run = 0;
                end
                ready = (m_busy_left == 0);
                if (ready && auto_en) begin
                    m_ready_age++;
                    if (m_ready_age == AUTO_PERIOD) begin
                        m_ready_age = 0;
                        req = 1;
                    end
                end else begin
                    m_ready_age = 0;
                end
                if (ready) begin
                    if (m_pending || req) begin
                        m_toggle = 1;
                        m_phase = !m_phase;
                        m_pending = m_pending && req;
                        m_busy_left = AMBER_TIME + 2 + MIN_DWELL;
                    end
                end else begin
                    if (req) m_pending = 1;
                    m_busy_left--;
                end
            end
            m_s2 = m_s1;
            m_s1 = button;
        end
    endtask

    // ---------------- compare / monitor process ----------------
    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        check("toggle", toggle, m_toggle);
        check("phase", phase, m_phase);
        check("pending", pending, m_pending);
        check("busy", busy, m_busy_left != 0);
        if (toggle) begin
            check("toggle_width", tog_prev, 0);
            tog_count++;
            prev_tog = last_tog;
            last_tog = cyc;
            busy_run = 1;
            busy_track = 1;
            if (exp_q.size() > 0) check("phase_seq", phase, exp_q.pop_front());
        end else if (busy_track) begin
            if (busy) busy_run++;
            else begin
                last_busy_run = busy_run;
                busy_track = 0;
            end
        end
        tog_prev = toggle;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_toggle(input int budget);
        int c0;
        c0 = tog_count;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tog_count != c0) return;
        end
        total++;
        bad++;
        $display("FAIL toggle_timeout: got no pulse expected one within %0d clks", budget);
    endtask

    // Minimal accepted press: 4 clks high, 4 clks low.
    task automatic press();
        button = 1'b1;
        repeat (4) @(negedge clk);
        button = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    int rel;
    int t1;
    int n0;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_toggle", toggle, 0);
        check("rst_phase", phase, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 1);

        // Button held high from cycle 20: one pulse, busy 5+8 after it
        reset_n = 1'b1;
        rel = cyc;
        repeat (20) @(negedge clk);
        button = 1'b1;
        wait_toggle(60);
        check("first_press_latency", last_tog - rel, 26);
        check("phase_after_press", phase, 1);
        repeat (20) @(negedge clk);
        check("single_pulse", tog_count, 1);
        check("busy_span", last_busy_run, 13);

        // Two-clk glitch after a clean release: no request
        button = 1'b0;
        repeat (20) @(negedge clk);
        n0 = tog_count;
        button = 1'b1;
        repeat (2) @(negedge clk);
        button = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_no_toggle", tog_count - n0, 0);
        check("glitch_no_pending", pending, 0);

        // Press accepted at HOLD dwell count 3 after an auto fire
        auto_en = 1'b1;
        wait_toggle(60);
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        button = 1'b1;
        repeat (7) @(negedge clk);
        check("hold_press_pending", pending, 1);
        button = 1'b0;
        wait_toggle(40);
        check("hold_press_interval", last_tog - prev_tog, 14);
        check("hold_press_served", pending, 0);

        // Two presses in one busy interval: a single extra pulse
        repeat (15) @(negedge clk);
        auto_en = 1'b1;
        wait_toggle(60);
        t1 = last_tog;
        n0 = tog_count;
        repeat (28) @(negedge clk);
        press();
        auto_en = 1'b0;
        press();
        wait_toggle(40);
        check("auto_interval", prev_tog - t1, 33);
        check("merged_interval", last_tog - prev_tog, 14);
        repeat (40) @(negedge clk);
        check("merged_count", tog_count - n0, 2);
        check("merged_pending", pending, 0);

        // Auto mode from reset: phases 1,0,1, 33-clk period, then ce at 50%
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        auto_en = 1'b1;
        wait_toggle(60);
        check("auto_first_latency", last_tog - rel, 28);
        wait_toggle(60);
        check("auto_period_a", last_tog - prev_tog, 33);
        wait_toggle(60);
        check("auto_period_b", last_tog - prev_tog, 33);
        ce_half = 1'b1;
        wait_toggle(140);
        wait_toggle(140);
        check("half_ce_period_a", last_tog - prev_tog, 66);
        wait_toggle(140);
        check("half_ce_period_b", last_tog - prev_tog, 66);
        ce_half = 1'b0;

        // Reset asserted while the pulse is high, in WAIT
        wait_toggle(100);
        check("pre_reset_toggle", toggle, 1);
        reset_n = 1'b0;
        #1;
        check("async_toggle", toggle, 0);
        check("async_phase", phase, 0);
        check("async_pending", pending, 0);
        check("async_busy", busy, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        wait_toggle(60);
        check("restart_latency", last_tog - rel, 28);
        check("restart_phase", phase, 1);
        auto_en = 1'b0;
        repeat (5) @(negedge clk);
        check("phase_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
